multi: RTL and testbench

MULTI -- requirements
Module: multi

---
 rtl/multi.sv | 146 ++++++++++++++
 tb/tb_multi.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/multi.sv
// Two-entry multiplier reservation station (M0/M1). It snoops the result buses
// for pending operands and broadcasts {tag, low 32 bits of product} on multout.
module multi (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] reg0,
    input  logic [31:0] reg1,
    input  logic [31:0] reg2,
    input  logic [31:0] reg3,
    input  logic [39:0] loadbus,
    input  logic [39:0] addbus,
    input  logic [39:0] multbus,
    input  logic [39:0] instbus1,
    input  logic [39:0] instbus2,
    output logic [39:0] multout
);

    localparam logic [7:0] OP_MULT = 8'h04;
    localparam logic [7:0] TAG_M0  = 8'h30;
    localparam logic [7:0] TAG_M1  = 8'h31;

    typedef struct packed {
        logic        busy;
        logic [31:0] v1;
        logic [31:0] v2;
        logic        ok1;
        logic        ok2;
        logic [7:0]  t1;
        logic [7:0]  t2;
        logic [7:0]  dest;
    } ent_t;

    ent_t        ent      [2];
    ent_t        ent_nxt  [2];
    logic [39:0] prev1;
    logic [39:0] prev2;
    logic [1:0]  ready;
    logic [1:0]  fire;
    logic [1:0]  free;
    logic [1:0]  take1;
    logic [1:0]  take2;
    logic        new1;
    logic        new2;
    logic        mul1;
    logic        mul2;

    // A zero tag never names a producer; an unknown tag compares as X and is
    // therefore never taken by the if-statements that use this.
    function automatic logic hit(input logic [7:0] tag, input logic [39:0] bus);
        return (tag != 8'h00) && (bus[39:32] == tag);
    endfunction

    function automatic logic [32:0] snoop(input logic ok, input logic [7:0] tag,
                                          input logic [31:0] val);
        logic [32:0] r;
        r = {ok, val};
        if (!ok) begin
            if (hit(tag, loadbus))      r = {1'b1, loadbus[31:0]};
            else if (hit(tag, addbus))  r = {1'b1, addbus[31:0]};
            else if (hit(tag, multbus)) r = {1'b1, multbus[31:0]};
        end
        return r;
    endfunction

    function automatic logic [32:0] src_op(input logic [7:0] src);
        case (src)
            8'h10:   return {1'b1, reg0};
            8'h11:   return {1'b1, reg1};
            8'h12:   return {1'b1, reg2};
            8'h13:   return {1'b1, reg3};
            default: return snoop(1'b0, src, 32'h0);
        endcase
    endfunction

    function automatic ent_t build(input logic [39:0] ins);
        ent_t        e;
        logic [32:0] a;
        logic [32:0] b;
        a      = src_op(ins[23:16]);
        b      = src_op(ins[15:8]);
        e.busy = 1'b1;
        e.ok1  = a[32];
        e.v1   = a[31:0];
        e.ok2  = b[32];
        e.v2   = b[31:0];
        e.t1   = ins[23:16];
        e.t2   = ins[15:8];
        e.dest = ins[7:0];
        return e;
    endfunction

    function automatic logic [31:0] mul_lo(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            ready[i] = ent[i].busy && ent[i].ok1 && ent[i].ok2;
        end
        fire[0] = ready[0];
        fire[1] = ready[1] && !ready[0];
        // An entry broadcasting this edge may be refilled on the same edge.
        free    = ~{ent[1].busy, ent[0].busy} | fire;

        new1     = (instbus1 != prev1);
        new2     = (instbus2 != prev2);
        mul1     = new1 && (instbus1[31:24] == OP_MULT);
        mul2     = new2 && (instbus2[31:24] == OP_MULT);
        take1[0] = mul1 && (instbus1[39:32] == TAG_M0) && free[0];
        take1[1] = mul1 && (instbus1[39:32] == TAG_M1) && free[1];
        take2[0] = mul2 && (instbus2[39:32] == TAG_M0) && free[0] && !take1[0];
        take2[1] = mul2 && (instbus2[39:32] == TAG_M1) && free[1] && !take1[1];

        for (int i = 0; i < 2; i++) begin
            ent_nxt[i] = ent[i];
            if (fire[i]) begin
                ent_nxt[i].busy = 1'b0;
                ent_nxt[i].ok1  = 1'b0;
                ent_nxt[i].ok2  = 1'b0;
            end else if (ent[i].busy) begin
                {ent_nxt[i].ok1, ent_nxt[i].v1} = snoop(ent[i].ok1, ent[i].t1, ent[i].v1);
                {ent_nxt[i].ok2, ent_nxt[i].v2} = snoop(ent[i].ok2, ent[i].t2, ent[i].v2);
            end
            if (take1[i])      ent_nxt[i] = build(instbus1);
            else if (take2[i]) ent_nxt[i] = build(instbus2);
        end
    end

    // Stage boundary: entry state, previous-instruction history and broadcast.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) ent[i] <= '0;
            prev1   <= 40'h0;
            prev2   <= 40'h0;
            multout <= 40'h0;
        end else begin
            for (int i = 0; i < 2; i++) ent[i] <= ent_nxt[i];
            prev1 <= instbus1;
            prev2 <= instbus2;
            if (fire[0])      multout <= {TAG_M0, mul_lo(ent[0].v1, ent[0].v2)};
            else if (fire[1]) multout <= {TAG_M1, mul_lo(ent[1].v1, ent[1].v2)};
            else              multout <= 40'h0;
        end
    end

endmodule

// File: tb/tb_multi.sv
// Scoreboard bench for multi: expected broadcasts are queued with their due
// cycle when stimulus is driven and compared against multout every cycle.
module tb_multi;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg0, reg1, reg2, reg3;
    logic [39:0] loadbus, addbus, multbus, instbus1, instbus2;
    logic [39:0] multout;

    typedef struct {
        int          cyc;
        logic [39:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;

    multi dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .reg0     (reg0),
        .reg1     (reg1),
        .reg2     (reg2),
        .reg3     (reg3),
        .loadbus  (loadbus),
        .addbus   (addbus),
        .multbus  (multbus),
        .instbus1 (instbus1),
        .instbus2 (instbus2),
        .multout  (multout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Stimulus completed after edge k dispatches/captures at k+1, broadcasts at k+2.
    task automatic push(input logic [39:0] v);
        exp_t e;
        e.cyc = cyc + 2;
        e.val = v;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            chk($sformatf("bcast_due%0d", e.cyc), multout, e.val);
        end else begin
            chk("idle", multout, 40'h0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        reg0     = 32'h3;
        reg1     = 32'h22;
        reg2     = 32'h4;
        reg3     = 32'h5;
        loadbus  = 40'h0;
        addbus   = 40'h0;
        multbus  = 40'h0;
        instbus1 = 40'h0;
        instbus2 = 40'h0;
        #1 chk("rst_async", multout, 40'h0);
        repeat (3) @(posedge clk);
        #1 chk("rst_hold", multout, 40'h0);
        @(negedge clk) rst_n = 1'b1;

        // Two dependent instructions, completed out of order, held afterwards.
        step(1);
        instbus1 = 40'h30_04_20_12_13;
        instbus2 = 40'h31_04_40_11_12;
        step(1);
        loadbus = 40'h40_00000034;
        push(40'h31_000006E8);
        step(1);
        loadbus = 40'h0;
        addbus  = 40'h20_00001122;
        push(40'h30_00004488);
        step(1);
        addbus = 40'h0;
        step(3);
        loadbus = 40'h40_00000034;
        addbus  = 40'h20_00001122;
        step(1);
        loadbus  = 40'h0;
        addbus   = 40'h0;
        step(2);
        instbus1 = 40'h0;
        instbus2 = 40'h0;
        step(2);

        // Register-only operands.
        instbus1 = 40'h30_04_10_13_00;
        push(40'h30_0000000F);
        step(3);
        instbus1 = 40'h0;
        step(2);

        // Bypass: pending tag on the add bus in the dispatch cycle.
        instbus1 = 40'h31_04_21_10_00;
        addbus   = 40'h21_00000007;
        push(40'h31_00000015);
        step(1);
        addbus = 40'h0;
        step(2);
        instbus1 = 40'h0;
        step(2);

        // Both entries ready together; M1 operand arrives on multbus.
        instbus1 = 40'h30_04_40_11_00;
        instbus2 = 40'h31_04_41_12_00;
        step(1);
        loadbus = 40'h40_00000002;
        multbus = 40'h41_00000003;
        push(40'h30_00000044);
        exp_q.push_back('{cyc + 3, 40'h31_0000000C});
        step(1);
        loadbus = 40'h0;
        multbus = 40'h0;
        step(3);
        instbus1 = 40'h0;
        instbus2 = 40'h0;
        step(2);

        // Truncated product, then a non-multiply opcode.
        reg0     = 32'hFFFF_FFFF;
        reg3     = 32'h2;
        instbus1 = 40'h30_04_10_13_00;
        push(40'h30_FFFFFFFE);
        step(3);
        instbus1 = 40'h31_03_10_13_00;
        step(3);
        instbus1 = 40'h0;
        reg0     = 32'h3;
        reg3     = 32'h5;
        step(2);

        // Same free entry on both buses: instbus1 wins, instbus2 dropped.
        instbus1 = 40'h30_04_10_10_00;
        instbus2 = 40'h30_04_13_13_00;
        push(40'h30_00000009);
        step(4);
        instbus1 = 40'h0;
        instbus2 = 40'h0;
        step(2);

        // Dispatch to a busy entry is ignored.
        instbus1 = 40'h30_04_43_10_00;
        step(1);
        instbus2 = 40'h30_04_10_13_00;
        step(1);
        loadbus = 40'h43_00000006;
        push(40'h30_00000012);
        step(1);
        loadbus = 40'h0;
        step(3);
        instbus1 = 40'h0;
        instbus2 = 40'h0;
        step(2);

        // Reset while an entry is ready discards it; held instruction dispatches after release.
        instbus1 = 40'h31_04_42_10_00;
        step(1);
        loadbus = 40'h42_00000005;
        step(1);
        rst_n   = 1'b0;
        loadbus = 40'h0;
        #1 chk("rst_mid", multout, 40'h0);
        instbus1 = 40'h30_04_10_13_00;
        repeat (2) @(posedge clk);
        #1 chk("rst_mid_hold", multout, 40'h0);
        @(negedge clk) rst_n = 1'b1;
        push(40'h30_0000000F);
        step(3);
        loadbus = 40'h42_00000005;
        step(1);
        loadbus  = 40'h0;
        instbus1 = 40'h0;
        step(4);

        chk("drain", 40'(exp_q.size()), 40'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
